// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: programmable tick divider; rate changes take effect only at period boundaries.
// Optional GAME_TICK_STATS_EN adds change_cnt, a saturating count of applied changes that moved the divider.
module game_tick_scheduler #(
  parameter int DIV_W    = 28,
  parameter int DIV_INIT = 25_000_000,
  parameter int DIV_MIN  = 2_500_000,
  parameter int DIV_MAX  = 50_000_000,
  parameter int DIV_STEP = 1_250_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             speed_up,
  input  logic             slow_down,
  input  logic             load_req,
  input  logic [DIV_W-1:0] load_val,
  output logic             load_ack,
  output logic             pending,
  output logic [DIV_W-1:0] divider,
  output logic             tick,
  output logic             div_clk
`ifdef GAME_TICK_STATS_EN
  ,
  output logic [7:0]       change_cnt
`endif
);
  typedef enum logic {IDLE, PEND} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_UP, OP_DN, OP_LD} op_t;
  localparam logic [DIV_W:0] MIN_W  = (DIV_W+1)'(DIV_MIN);
  localparam logic [DIV_W:0] MAX_W  = (DIV_W+1)'(DIV_MAX);
  localparam logic [DIV_W:0] STEP_W = (DIV_W+1)'(DIV_STEP);
  state_t           state;
  op_t              op, req_op;
  logic [DIV_W-1:0] counter, lv;
  logic [DIV_W:0]   d_w, l_w, up_w, dn_w, ld_w, nxt_w;
  logic             apply;
  assign tick    = counter == divider - DIV_W'(1);
  assign div_clk = counter >= (divider >> 1);
  assign pending = state == PEND;
  assign apply   = tick && state == PEND;
  // One extra bit keeps divider+STEP from wrapping before the clamp.
  always_comb begin
    d_w    = {1'b0, divider};
    l_w    = {1'b0, lv};
    up_w   = d_w < MIN_W + STEP_W ? MIN_W : d_w - STEP_W;
    dn_w   = d_w + STEP_W > MAX_W ? MAX_W : d_w + STEP_W;
    ld_w   = l_w < MIN_W ? MIN_W : (l_w > MAX_W ? MAX_W : l_w);
    nxt_w  = op == OP_LD ? ld_w : op == OP_UP ? up_w : op == OP_DN ? dn_w : d_w;
    req_op = load_req ? OP_LD : (speed_up && !slow_down) ? OP_UP :
             (slow_down && !speed_up) ? OP_DN : OP_NONE;
  end
  // A request arriving on the applying edge is kept for the next period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter  <= '0;
      divider  <= DIV_W'(DIV_INIT);
      state    <= IDLE;
      op       <= OP_NONE;
      lv       <= '0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= apply && op == OP_LD;
      counter  <= tick ? '0 : counter + DIV_W'(1);
      if (apply) divider <= nxt_w[DIV_W-1:0];
      if (req_op != OP_NONE) begin
        state <= PEND;
        op    <= req_op;
        lv    <= load_val;
      end else if (apply) begin
        state <= IDLE;
        op    <= OP_NONE;
      end
    end
  end
`ifdef GAME_TICK_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) change_cnt <= '0;
    else if (apply && nxt_w[DIV_W-1:0] != divider && change_cnt != 8'hff) change_cnt <= change_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_game_tick_scheduler.sv
// tb_game_tick_scheduler: directed checks of period, rate steps, loads, clamping, priority and reset.
module tb_game_tick_scheduler;
  logic       clk = 0, rst_n = 0, speed_up = 0, slow_down = 0, load_req = 0;
  logic [7:0] load_val = 0, divider;
  logic       load_ack, pending, tick, div_clk;
  int         n_cmp = 0, n_bad = 0;
`ifdef GAME_TICK_STATS_EN
  logic [7:0] change_cnt;
`endif

  game_tick_scheduler #(.DIV_W(8), .DIV_INIT(10), .DIV_MIN(4), .DIV_MAX(14), .DIV_STEP(2)) dut (
    .clk(clk), .rst_n(rst_n), .speed_up(speed_up), .slow_down(slow_down),
    .load_req(load_req), .load_val(load_val), .load_ack(load_ack), .pending(pending),
    .divider(divider), .tick(tick), .div_clk(div_clk)
`ifdef GAME_TICK_STATS_EN
    , .change_cnt(change_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    step(2);
    chk("rst_pending", pending, 0);
    chk("rst_divider", divider, 10);
    chk("rst_tick", tick, 0);
    chk("rst_divclk", div_clk, 0);
    chk("rst_ack", load_ack, 0);
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      chk("period_tick", tick, (i % 10) == 9);
      chk("period_divclk", div_clk, (i % 10) >= 5);
      step(1);
    end
    step(3);
    speed_up = 1; step(1); speed_up = 0;
    chk("up_pending", pending, 1);
    step(5);
    chk("up_tick", tick, 1);
    chk("up_old_div", divider, 10);
    step(1);
    chk("up_div8", divider, 8);
    chk("up_pend_clr", pending, 0);
    chk("up_no_ack", load_ack, 0);
    step(3);
    chk("p8_divclk_lo", div_clk, 0);
    step(1);
    chk("p8_divclk_hi", div_clk, 1);
    step(3);
    chk("p8_tick", tick, 1);
    step(1);
    chk("p8_wrap", tick, 0);
    speed_up = 1; step(1); speed_up = 0;
    step(7);
    chk("div6", divider, 6);
    speed_up = 1; step(1); speed_up = 0;
    step(5);
    chk("div4", divider, 4);
    speed_up = 1; step(1); speed_up = 0;
    step(3);
    chk("min_hold", divider, 4);
    chk("min_pend_clr", pending, 0);
`ifdef GAME_TICK_STATS_EN
    chk("cnt_min", change_cnt, 3);
`endif
    load_req = 1; load_val = 1; speed_up = 1; step(1); load_req = 0; speed_up = 0;
    chk("ld1_pending", pending, 1);
    step(2);
    chk("ld1_no_ack_yet", load_ack, 0);
    step(1);
    chk("ld1_div", divider, 4);
    chk("ld1_ack", load_ack, 1);
    load_req = 1; load_val = 12; step(1); load_req = 0;
    chk("ack_one_pulse", load_ack, 0);
    step(2);
    chk("ld12_pre", divider, 4);
    step(1);
    chk("ld12_div", divider, 12);
    chk("ld12_ack", load_ack, 1);
    step(11);
    chk("tickreq_tick", tick, 1);
    slow_down = 1; step(1); slow_down = 0;
    chk("tickreq_not_now", divider, 12);
    chk("tickreq_pending", pending, 1);
    step(11);
    chk("tickreq_still12", divider, 12);
    step(1);
    chk("tickreq_div14", divider, 14);
    chk("step_no_ack", load_ack, 0);
    load_req = 1; load_val = 10; step(1); load_req = 0;
    step(13);
    chk("ld10_div", divider, 10);
    step(2);
    speed_up = 1; step(1); speed_up = 0;
    step(2);
    slow_down = 1; step(1); slow_down = 0;
    step(3);
    chk("lastwins_pending", pending, 1);
    step(1);
    chk("lastwins_div12", divider, 12);
    load_req = 1; load_val = 200; step(1); load_req = 0;
    step(11);
    chk("ldclamp_max", divider, 14);
    slow_down = 1; step(1); slow_down = 0;
    step(13);
    chk("max_hold", divider, 14);
`ifdef GAME_TICK_STATS_EN
    chk("cnt_max", change_cnt, 8);
`endif
    speed_up = 1; slow_down = 1; step(1); speed_up = 0; slow_down = 0;
    chk("both_ignored", pending, 0);
    step(5);
    speed_up = 1; step(1); speed_up = 0;
    chk("pre_rst_pending", pending, 1);
    chk("pre_rst_divclk", div_clk, 1);
    rst_n = 0; #1;
    chk("async_pending", pending, 0);
    chk("async_divider", divider, 10);
    chk("async_divclk", div_clk, 0);
`ifdef GAME_TICK_STATS_EN
    chk("async_cnt", change_cnt, 0);
`endif
    step(1);
    rst_n = 1;
    step(8);
    chk("post_rst_notick", tick, 0);
    step(1);
    chk("post_rst_tick", tick, 1);
    step(1);
    chk("post_rst_div", divider, 10);
    chk("post_rst_pend", pending, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/game_tick_scheduler.md
GAME_TICK_SCHEDULER -- requirements
Module: game_tick_scheduler

Interface
REQ-001 Parameter DIV_W, default 28: width of divider and counter.
REQ-002 Parameter DIV_INIT, default 25_000_000: divider after reset.
REQ-003 Parameter DIV_MIN, default 2_500_000: lowest divider, which is the fastest rate.
REQ-004 Parameter DIV_MAX, default 50_000_000: highest divider, which is the slowest rate.
REQ-005 Parameter DIV_STEP, default 1_250_000: divider change per speed request.
REQ-006 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port speed_up, input, 1 bit: request to decrease the divider by DIV_STEP, sampled every cycle.
REQ-009 Port slow_down, input, 1 bit: request to increase the divider by DIV_STEP, sampled every cycle.
REQ-010 Port load_req, input, 1 bit: request to load load_val as the divider.
REQ-011 Port load_val, input, DIV_W bits: divider value for load_req, sampled in the same cycle as load_req.
REQ-012 Port load_ack, output, 1 bit: one-cycle pulse when a load is applied.
REQ-013 Port pending, output, 1 bit: high while a divider change is waiting to be applied.
REQ-014 Port divider, output, DIV_W bits: the divider value currently in effect.
REQ-015 Port tick, output, 1 bit: one-cycle pulse on the last cycle of each period.
REQ-016 Port div_clk, output, 1 bit: divided square wave.

Function
REQ-017 The counter SHALL count 0..divider-1 and return to 0 on the cycle after it reaches divider-1.
REQ-018 tick SHALL be high exactly when counter == divider-1.
REQ-019 div_clk SHALL be 0 while counter < divider/2, using integer division, and 1 otherwise.
REQ-020 The FSM SHALL have two states, IDLE and PEND; pending SHALL be high exactly in state PEND.
REQ-021 Same-cycle request priority SHALL be: load_req first, then speed_up/slow_down.
REQ-022 If speed_up and slow_down are both high without load_req, that cycle's request SHALL be ignored.
REQ-023 An accepted request SHALL move the FSM to PEND on the next edge and latch the operation code plus load_val.
REQ-024 A new request while in PEND SHALL overwrite the latched operation (last request wins) and SHALL stay in PEND.
REQ-025 A change SHALL be applied only on the edge that ends a period (tick high and state PEND).
REQ-026 When applied, divider SHALL take the new value, counter SHALL go to 0, and the FSM SHALL return to IDLE, all on that edge.
REQ-027 A request sampled on a tick cycle SHALL NOT apply on that edge; it SHALL apply at the end of the following period.
REQ-028 Divider arithmetic SHALL be done at DIV_W+1 bits; speed_up SHALL give max(divider-DIV_STEP, DIV_MIN).
REQ-029 slow_down SHALL give min(divider+DIV_STEP, DIV_MAX).
REQ-030 A load SHALL clamp load_val to the range DIV_MIN..DIV_MAX.
REQ-031 load_ack SHALL pulse high in the cycle after a load is applied, and SHALL NOT pulse for step requests.
REQ-032 DIV_MIN SHALL be at least 2, so tick and div_clk never stay constant.

Reset
REQ-033 While rst_n is low: counter = 0, divider = DIV_INIT, FSM = IDLE, latched operation cleared.
REQ-034 While rst_n is low: pending = 0, load_ack = 0, tick = 0, div_clk = 0.
REQ-035 Reset asserted mid-period or while in PEND SHALL discard the pending change.
REQ-036 After reset release, the first tick SHALL occur DIV_INIT cycles later.

Configuration
REQ-037 With GAME_TICK_STATS_EN defined, the block SHALL add output change_cnt (8 bits), reset to 0.
REQ-038 With GAME_TICK_STATS_EN defined, change_cnt SHALL increment on every applied change whose new divider differs from the old one, saturating at 255.
REQ-039 Without GAME_TICK_STATS_EN, the change_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-040 Reset, DIV_INIT=10, no requests -> tick every 10 cycles; div_clk low 5 cycles, high 5 cycles.
REQ-041 DIV_INIT=10, DIV_STEP=2, one-cycle speed_up at counter=3 -> pending high until the wrap; next period is 8 cycles; divider=8.
REQ-042 Divider at DIV_MIN, speed_up -> divider stays at DIV_MIN; with STATS_EN, change_cnt does not increment.
REQ-043 load_req with load_val=1 and speed_up in the same cycle, DIV_MIN=4 -> divider=4 at the wrap; load_ack one pulse.
REQ-044 speed_up at counter=2, then slow_down at counter=5, DIV_INIT=10, DIV_STEP=2 -> divider=12 at the wrap (last request wins).
REQ-045 rst_n low while pending at counter=7 -> pending=0, divider=DIV_INIT, counter=0; the request is never applied.
